// File: rtl/easyaxi_rd_mst.sv
// AXI read initiator: queues read commands, issues AR in order and checks each
// in-order R beat against the expected {ID, address} pattern.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_mst #(
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [`AXI_ID_W-1:0]      req_id,
    input  logic [`AXI_ADDR_W-1:0]    req_addr,
    input  logic [`AXI_LEN_W-1:0]     req_len,
    input  logic [`AXI_SIZE_W-1:0]    req_size,
    input  logic [`AXI_BURST_W-1:0]   req_burst,
    output logic                      axi_mst_arvalid,
    input  logic                      axi_mst_arready,
    output logic [`AXI_ID_W-1:0]      axi_mst_arid,
    output logic [`AXI_ADDR_W-1:0]    axi_mst_araddr,
    output logic [`AXI_LEN_W-1:0]     axi_mst_arlen,
    output logic [`AXI_SIZE_W-1:0]    axi_mst_arsize,
    output logic [`AXI_BURST_W-1:0]   axi_mst_arburst,
    input  logic                      axi_mst_rvalid,
    output logic                      axi_mst_rready,
    input  logic [`AXI_ID_W-1:0]      axi_mst_rid,
    input  logic [`AXI_DATA_W-1:0]    axi_mst_rdata,
    input  logic [`AXI_RESP_W-1:0]    axi_mst_rresp,
    input  logic                      axi_mst_rlast,
    output logic                      cpl_valid,
    output logic [`AXI_ID_W-1:0]      cpl_id,
    output logic [`AXI_RESP_W-1:0]    cpl_resp,
    output logic                      cpl_err,
    output logic [$clog2(OST_DEPTH):0] ost_cnt
);

    localparam int unsigned PW = $clog2(OST_DEPTH);
    localparam int unsigned AW = `AXI_ADDR_W;
    localparam int unsigned IW = `AXI_ID_W;
    localparam logic [PW:0] FULL_CNT = OST_DEPTH[PW:0];

    typedef enum logic [1:0] {FREE, PEND_AR, WAIT_R} ent_state_t;

    ent_state_t               ent_state [OST_DEPTH];
    logic [`AXI_ID_W-1:0]     ent_id    [OST_DEPTH];
    logic [`AXI_ADDR_W-1:0]   ent_addr  [OST_DEPTH];
    logic [`AXI_LEN_W-1:0]    ent_len   [OST_DEPTH];
    logic [`AXI_SIZE_W-1:0]   ent_size  [OST_DEPTH];
    logic [`AXI_BURST_W-1:0]  ent_burst [OST_DEPTH];

    logic [PW-1:0]            set_ptr, ar_ptr, head_ptr;
    logic [`AXI_LEN_W-1:0]    beat_n;
    logic [`AXI_RESP_W-1:0]   resp_acc, resp_max;
    logic                     err_acc, beat_err, beat_last;
    logic                     alloc, ar_hs, r_hs;
    logic [AW-1:0]            exp_addr, bytes, step, wrap_mask, wrap_base;

    assign req_ready = enable & ~rst & (ost_cnt != FULL_CNT);
    assign alloc     = req_valid & req_ready;

    assign axi_mst_arvalid = (ent_state[ar_ptr] == PEND_AR);
    assign axi_mst_arid    = ent_id[ar_ptr];
    assign axi_mst_araddr  = ent_addr[ar_ptr];
    assign axi_mst_arlen   = ent_len[ar_ptr];
    assign axi_mst_arsize  = ent_size[ar_ptr];
    assign axi_mst_arburst = ent_burst[ar_ptr];
    assign ar_hs           = axi_mst_arvalid & axi_mst_arready;

    assign axi_mst_rready  = (ent_state[head_ptr] == WAIT_R);
    assign r_hs            = axi_mst_rvalid & axi_mst_rready;

    generate
        if (`AXI_DATA_W > AW + IW) begin : g_unused_data
            logic unused_rdata;
            assign unused_rdata = ^axi_mst_rdata[`AXI_DATA_W-1:AW+IW];
        end
    endgenerate

    // WRAP window is (len+1) << size bytes; legal WRAP lengths make it a power of 2
    always_comb begin
        bytes     = AW'(1) << ent_size[head_ptr];
        step      = AW'(beat_n) << ent_size[head_ptr];
        wrap_mask = ((AW'(ent_len[head_ptr]) + AW'(1)) << ent_size[head_ptr]) - AW'(1);
        wrap_base = ent_addr[head_ptr] & ~wrap_mask;
        exp_addr  = ent_addr[head_ptr];
        case (ent_burst[head_ptr])
            2'b00:   exp_addr = ent_addr[head_ptr];
            2'b10:   exp_addr = wrap_base + ((ent_addr[head_ptr] - wrap_base + step) & wrap_mask);
            default: exp_addr = (beat_n == '0) ? ent_addr[head_ptr]
                                : (ent_addr[head_ptr] & ~(bytes - AW'(1))) + step;
        endcase
        beat_last = (beat_n == ent_len[head_ptr]);
        beat_err  = (axi_mst_rid != ent_id[head_ptr])
                  | (axi_mst_rdata[AW-1:0] != exp_addr)
                  | (axi_mst_rdata[AW +: IW] != ent_id[head_ptr])
                  | (axi_mst_rlast != beat_last);
        resp_max  = (axi_mst_rresp > resp_acc) ? axi_mst_rresp : resp_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < OST_DEPTH; i++) begin
                ent_state[i] <= FREE;
                ent_id[i]    <= '0;
                ent_addr[i]  <= '0;
                ent_len[i]   <= '0;
                ent_size[i]  <= '0;
                ent_burst[i] <= '0;
            end
            set_ptr   <= '0;
            ar_ptr    <= '0;
            head_ptr  <= '0;
            beat_n    <= '0;
            resp_acc  <= '0;
            err_acc   <= 1'b0;
            cpl_valid <= 1'b0;
            cpl_id    <= '0;
            cpl_resp  <= '0;
            cpl_err   <= 1'b0;
            ost_cnt   <= '0;
        end else begin
            cpl_valid <= 1'b0;
            if (alloc) begin
                ent_state[set_ptr] <= PEND_AR;
                ent_id[set_ptr]    <= req_id;
                ent_addr[set_ptr]  <= req_addr;
                ent_len[set_ptr]   <= req_len;
                ent_size[set_ptr]  <= req_size;
                ent_burst[set_ptr] <= req_burst;
                set_ptr            <= set_ptr + 1'b1;
            end
            if (ar_hs) begin
                ent_state[ar_ptr] <= WAIT_R;
                ar_ptr            <= ar_ptr + 1'b1;
            end
            if (r_hs) begin
                if (beat_last) begin
                    cpl_valid           <= 1'b1;
                    cpl_id              <= ent_id[head_ptr];
                    cpl_resp            <= resp_max;
                    cpl_err             <= err_acc | beat_err;
                    ent_state[head_ptr] <= FREE;
                    head_ptr            <= head_ptr + 1'b1;
                    beat_n              <= '0;
                    resp_acc            <= '0;
                    err_acc             <= 1'b0;
                end else begin
                    beat_n   <= beat_n + 1'b1;
                    resp_acc <= resp_max;
                    err_acc  <= err_acc | beat_err;
                end
            end
            case ({alloc, r_hs & beat_last})
                2'b10:   ost_cnt <= ost_cnt + 1'b1;
                2'b01:   ost_cnt <= ost_cnt - 1'b1;
                default: ost_cnt <= ost_cnt;
            endcase
        end
    end

endmodule
